d_mem_loader: RTL and testbench
===============================

// Module: d_mem_loader
// PURPOSE
//  Initiator side of the data-memory write port: consumes a framed byte stream (UART/debug link)
//  and issues BYTE/HALF/WORD writes into data memory. Holds the core off the memory port while loading.
//  Frame: SYNC(0xA5), ADDR[4] LE, LEN[4] LE, PAYLOAD[LEN], CSUM (XOR of payload bytes).
// PARAMETERS
//  SyncByte   8'hA5  frame start marker, matched only in IDLE
//  AddrBytes  4      header address bytes; value truncated to DMemAddrWidth (config_pkg)
//  LenBytes   4      header length bytes; length in bytes
// PORTS
//  clk           in   1              system clock
//  reset         in   1              asynchronous, active-low reset
//  rx_data       in   8              stream byte
//  rx_valid      in   1              rx_data valid
//  rx_ready      out  1              loader accepts byte this cycle (xfer = rx_valid & rx_ready)
//  mem_addr      out  DMemAddrWidth  byte address of write
//  mem_width     out  mem_width_t    BYTE/HALF/WORD (mem_pkg)
//  mem_sign_extend out 1             constant 0
//  mem_data      out  32             write data, LSB-aligned
//  mem_write_enable out 1            one-cycle write strobe
//  busy          out  1              frame in progress (SYNC accepted .. CSUM handled); core hold
//  done          out  1              sticky: last frame ok; cleared on next SYNC accept
//  error         out  1              sticky: last frame failed; cleared on next SYNC accept
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE; rx_ready=0 then 1 from first cycle after release;
//   mem_write_enable=0, mem_addr=0, mem_data=0, mem_width=WORD, busy=0, done=0, error=0.
//   Reset mid-frame aborts with no further write; already-written words stay in memory.
//  States: IDLE -> ADDR -> LEN -> CHECK -> DATA <-> WRITE -> TAIL -> CSUM -> IDLE; ERR_DRAIN.
//  IDLE: rx_ready=1; non-SYNC bytes discarded; SYNC xfer -> ADDR, busy=1, done=error=0, csum=0.
//  ADDR/LEN: 4 xfers each, little-endian shift-in, byte counter 0..3.
//  CHECK (1 cycle, rx_ready=0): fail if addr[1:0]!=0 or addr+len > 2**DMemAddrWidth (compute in
//   DMemAddrWidth+33 bits, no wrap). Fail -> ERR_DRAIN; len==0 -> CSUM; else DATA.
//  DATA: rx_ready=1; each xfer: byte into word buffer lane k (k=byte count mod 4), csum ^= byte,
//   remaining--. 4th lane filled -> WRITE. remaining hits 0 with 1..3 lanes filled -> TAIL.
//  WRITE (1 cycle, rx_ready=0): we=1, width=WORD, addr=cur, data=buffer; cur+=4; then DATA,
//   or CSUM if remaining==0.
//  TAIL (rx_ready=0): 1 byte -> one BYTE write; 2 -> one HALF write; 3 -> HALF at cur then BYTE at
//   cur+2 (two consecutive strobe cycles). Never a WORD write on a partial word.
//  CSUM: rx_ready=1; next xfer compared to csum: match -> done=1 else error=1; busy=0; -> IDLE.
//  ERR_DRAIN: rx_ready=1, discards exactly len+1 bytes (payload+csum), no writes; then error=1,
//   busy=0, IDLE. Keeps the link in frame sync.
//  rx_ready is registered-state-derived (no comb path from rx_valid). Bytes offered while
//   rx_ready=0 are held by the source, not lost. SYNC value inside a frame is plain data.
//  mem_write_enable never asserted outside WRITE/TAIL; mem_data/addr/width stable while high.
//  Throughput: 4 bytes per 5 cycles worst case at full-rate input.
// STRUCTURE
//  mem_pkg: add loader_state_t enum and LoaderSync constant; reuse mem_width_t.
//  config_pkg: DMemAddrWidth (existing).
//  One sub-module: d_mem_loader_packer (lane counter, 32-bit word buffer, XOR checksum,
//   full/partial flags); FSM, header shift registers and address arithmetic stay in top.
// TESTING
//  1 A5, addr 0x100, len 8, 11 22 33 44 55 66 77 88, cs 0x88 -> WORD 0x44332211@0x100,
//    0x88776655@0x104, done=1, error=0, exactly 2 strobes.
//  2 len 3 at 0x20, AA BB CC, cs 0xDD -> HALF 0xBBAA@0x20, then BYTE 0xCC@0x22 next cycle; done=1.
//  3 addr 0x102 (misaligned), len 4 -> no strobe, 4+1 bytes drained, error=1, then new frame ok.
//  4 valid frame with wrong csum 0x00 -> all writes issued, error=1, done=0, busy drops.
//  5 reset low during 2nd payload word -> outputs at reset values immediately, no further strobe;
//    subsequent frame loads correctly.
//  6 garbage 00 FF 12 before SYNC, rx_valid toggling randomly; len 0 with cs 0x00 -> done=1, 0 writes.

Source files
------------

// File: rtl/d_mem_loader_pkg.sv
// Shared types and constants for the data-memory stream loader.
// Holds the memory-port width encoding, address width and loader FSM states.
package d_mem_loader_pkg;

    localparam int DMemAddrWidth = 16;

    localparam logic [7:0] LoaderSync = 8'hA5;
    localparam int         AddrBytes  = 4;
    localparam int         LenBytes   = 4;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_t;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_LEN       = 4'd2,
        S_CHECK     = 4'd3,
        S_DATA      = 4'd4,
        S_WRITE     = 4'd5,
        S_TAIL      = 4'd6,
        S_CSUM      = 4'd7,
        S_ERR_DRAIN = 4'd8
    } loader_state_t;

endpackage

// File: rtl/d_mem_loader_packer.sv
// Assembles payload bytes into a little-endian 32-bit word and keeps the running
// XOR checksum of every byte pushed since the last clear.
module d_mem_loader_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic        full_o,
    output logic        partial_o,
    output logic [1:0]  lanes_o,
    output logic [31:0] word_o,
    output logic [7:0]  csum_o
);

    logic [1:0]      lane_q, lane_d;
    logic [3:0][7:0] buf_q, buf_d;
    logic [7:0]      csum_q, csum_d;

    always_comb begin
        lane_d = lane_q;
        buf_d  = buf_q;
        csum_d = csum_q;
        if (clr_i) begin
            lane_d = '0;
            buf_d  = '0;
            csum_d = '0;
        end else if (push_i) begin
            buf_d[lane_q] = byte_i;
            csum_d        = csum_q ^ byte_i;
            lane_d        = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= '0;
            buf_q  <= '0;
            csum_q <= '0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
            csum_q <= csum_d;
        end
    end

    // full is the push that fills lane 3; the lane counter wraps to 0 on it
    assign full_o    = push_i && (lane_q == 2'd3);
    assign partial_o = (lane_q != 2'd0);
    assign lanes_o   = lane_q;
    assign word_o    = buf_q;
    assign csum_o    = csum_q;

endmodule

// File: rtl/d_mem_loader.sv
// Framed byte-stream loader driving the data-memory write port; holds the core
// off the port (busy) for the duration of each frame.
module d_mem_loader
    import d_mem_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [DMemAddrWidth-1:0] mem_addr,
    output mem_width_t               mem_width,
    output logic                     mem_sign_extend,
    output logic [31:0]              mem_data,
    output logic                     mem_write_enable,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam logic [DMemAddrWidth+32:0] MemBytes = {{32{1'b0}}, 1'b1, {DMemAddrWidth{1'b0}}};

    loader_state_t           state_q, state_d;
    logic                    rdy_en_q;
    logic [1:0]              hdr_cnt_q, hdr_cnt_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             len_q, len_d;
    logic [31:0]             rem_q, rem_d;
    logic [DMemAddrWidth-1:0] cur_q, cur_d;
    logic                    tail_hi_q, tail_hi_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    xfer;
    logic                    sync_hit;
    logic                    pk_push, pk_full, pk_partial;
    logic [1:0]              pk_lanes;
    logic [31:0]             pk_word;
    logic [7:0]              pk_csum;
    logic [DMemAddrWidth+32:0] end_addr;
    logic                    check_fail;
    logic                    addr_hi_unused;

    // ready is held low through reset and the first edge after it
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_ERR_DRAIN: rx_ready = rdy_en_q;
            default:                                          rx_ready = 1'b0;
        endcase
    end

    assign xfer     = rx_valid && rx_ready;
    assign sync_hit = (state_q == S_IDLE) && xfer && (rx_data == LoaderSync);
    assign pk_push  = (state_q == S_DATA) && xfer;

    d_mem_loader_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (sync_hit),
        .push_i    (pk_push),
        .byte_i    (rx_data),
        .full_o    (pk_full),
        .partial_o (pk_partial),
        .lanes_o   (pk_lanes),
        .word_o    (pk_word),
        .csum_o    (pk_csum)
    );

    // Extra headroom bits so addr+len cannot wrap before the bound compare
    assign end_addr   = {33'b0, addr_q[DMemAddrWidth-1:0]} + {{(DMemAddrWidth+1){1'b0}}, len_q};
    assign check_fail = (addr_q[1:0] != 2'b00) || (end_addr > MemBytes);
    assign addr_hi_unused = ^addr_q[31:DMemAddrWidth];

    always_comb begin
        state_d          = state_q;
        hdr_cnt_d        = hdr_cnt_q;
        addr_d           = addr_q;
        len_d            = len_q;
        rem_d            = rem_q;
        cur_d            = cur_q;
        tail_hi_d        = tail_hi_q;
        done_d           = done_q;
        error_d          = error_q;
        mem_write_enable = 1'b0;
        mem_width        = WORD;
        mem_data         = '0;
        case (state_q)
            S_IDLE: begin
                if (sync_hit) begin
                    state_d   = S_ADDR;
                    hdr_cnt_d = '0;
                    tail_hi_d = 1'b0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                end
            end
            S_ADDR: begin
                if (xfer) begin
                    addr_d    = {rx_data, addr_q[31:8]};
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'(AddrBytes - 1)) state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    len_d     = {rx_data, len_q[31:8]};
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'(LenBytes - 1)) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                cur_d = addr_q[DMemAddrWidth-1:0];
                rem_d = len_q;
                if (check_fail)        state_d = S_ERR_DRAIN;
                else if (len_q == '0)  state_d = S_CSUM;
                else                   state_d = S_DATA;
            end
            S_DATA: begin
                if (xfer) begin
                    rem_d = rem_q - 32'd1;
                    if (pk_full)              state_d = S_WRITE;
                    else if (rem_q == 32'd1)  state_d = S_TAIL;
                end
            end
            S_WRITE: begin
                mem_write_enable = 1'b1;
                mem_width        = WORD;
                mem_data         = pk_word;
                cur_d            = cur_q + DMemAddrWidth'(4);
                state_d          = (rem_q == '0) ? S_CSUM : S_DATA;
            end
            S_TAIL: begin
                // A 3-byte tail splits into HALF at cur then BYTE at cur+2
                mem_write_enable = pk_partial;
                state_d          = S_CSUM;
                case (pk_lanes)
                    2'd1: begin
                        mem_width = BYTE;
                        mem_data  = {24'b0, pk_word[7:0]};
                    end
                    2'd2: begin
                        mem_width = HALF;
                        mem_data  = {16'b0, pk_word[15:0]};
                    end
                    2'd3: begin
                        if (!tail_hi_q) begin
                            mem_width = HALF;
                            mem_data  = {16'b0, pk_word[15:0]};
                            cur_d     = cur_q + DMemAddrWidth'(2);
                            tail_hi_d = 1'b1;
                            state_d   = S_TAIL;
                        end else begin
                            mem_width = BYTE;
                            mem_data  = {24'b0, pk_word[23:16]};
                            tail_hi_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            S_CSUM: begin
                if (xfer) begin
                    if (rx_data == pk_csum) done_d  = 1'b1;
                    else                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR_DRAIN: begin
                // rem counts payload bytes left; the byte seen at rem==0 is the checksum
                if (xfer) begin
                    if (rem_q == '0) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rem_d = rem_q - 32'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rdy_en_q  <= 1'b0;
            hdr_cnt_q <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            cur_q     <= '0;
            tail_hi_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_en_q  <= 1'b1;
            hdr_cnt_q <= hdr_cnt_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            cur_q     <= cur_d;
            tail_hi_q <= tail_hi_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign mem_addr        = cur_q;
    assign mem_sign_extend = 1'b0;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign error           = error_q;

endmodule

// File: tb/tb_d_mem_loader.sv
// Directed bench for d_mem_loader: frame loads, tails, header faults, bad checksum,
// mid-frame reset and noisy link start-up.
module tb_d_mem_loader;
    import d_mem_loader_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [DMemAddrWidth-1:0] mem_addr;
    mem_width_t               mem_width;
    logic                     mem_sign_extend;
    logic [31:0]              mem_data;
    logic                     mem_write_enable;
    logic                     busy, done, error;

    int chk_n  = 0;
    int pass_n = 0;
    bit jitter = 1'b0;

    int                       wr_n = 0;
    logic [DMemAddrWidth-1:0] log_a [0:63];
    logic [31:0]              log_d [0:63];
    mem_width_t               log_w [0:63];
    time                      log_t [0:63];

    d_mem_loader dut (
        .clk              (clk),
        .reset            (rst_n),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .mem_addr         (mem_addr),
        .mem_width        (mem_width),
        .mem_sign_extend  (mem_sign_extend),
        .mem_data         (mem_data),
        .mem_write_enable (mem_write_enable),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_write_enable === 1'b1 && wr_n < 64) begin
            log_a[wr_n] <= mem_addr;
            log_d[wr_n] <= mem_data;
            log_w[wr_n] <= mem_width;
            log_t[wr_n] <= $time;
            wr_n        <= wr_n + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (jitter) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk_n++;
            $display("FAIL send_timeout: byte %02h not accepted, rx_ready=%b want 1", b, rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] a, input logic [31:0] l);
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8]);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_n++; if (rx_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", rx_ready); else pass_n++;
        chk_n++; if (mem_write_enable !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_write_enable); else pass_n++;
        chk_n++; if (mem_addr !== '0 || mem_data !== 32'h0) $display("FAIL rst_addr_data: got %h/%h want 0/0", mem_addr, mem_data); else pass_n++;
        chk_n++; if (mem_width !== WORD) $display("FAIL rst_width: got %0d want %0d", mem_width, WORD); else pass_n++;
        chk_n++; if ({busy, done, error} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {busy, done, error}); else pass_n++;
        chk_n++; if (mem_sign_extend !== 1'b0) $display("FAIL sign_ext: got %b want 0", mem_sign_extend); else pass_n++;
        rst_n = 1'b1;
        @(negedge clk);
        chk_n++; if (rx_ready !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", rx_ready); else pass_n++;
    endtask

    task automatic test_word_frame;
        int b;
        logic [7:0] pl [0:7];
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        b = wr_n;
        send_hdr(32'h0000_0100, 32'd8);
        chk_n++; if (busy !== 1'b1) $display("FAIL word_busy: got %b want 1", busy); else pass_n++;
        for (int i = 0; i < 8; i++) send_byte(pl[i]);
        send_byte(8'h88);
        repeat (2) @(negedge clk);
        chk_n++; if (wr_n - b !== 2) $display("FAIL word_cnt: got %0d want 2", wr_n - b); else pass_n++;
        chk_n++; if (log_a[b] !== 16'h0100 || log_d[b] !== 32'h44332211 || log_w[b] !== WORD)
            $display("FAIL word0: got %h@%h w%0d want 44332211@0100 w2", log_d[b], log_a[b], log_w[b]); else pass_n++;
        chk_n++; if (log_a[b+1] !== 16'h0104 || log_d[b+1] !== 32'h88776655 || log_w[b+1] !== WORD)
            $display("FAIL word1: got %h@%h w%0d want 88776655@0104 w2", log_d[b+1], log_a[b+1], log_w[b+1]); else pass_n++;
        chk_n++; if ({busy, done, error} !== 3'b010) $display("FAIL word_flags: got %b want 010", {busy, done, error}); else pass_n++;
    endtask

    task automatic test_tail3;
        int b;
        b = wr_n;
        send_hdr(32'h0000_0020, 32'd3);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'hDD);
        repeat (2) @(negedge clk);
        chk_n++; if (wr_n - b !== 2) $display("FAIL tail_cnt: got %0d want 2", wr_n - b); else pass_n++;
        chk_n++; if (log_a[b] !== 16'h0020 || log_d[b] !== 32'h0000BBAA || log_w[b] !== HALF)
            $display("FAIL tail_half: got %h@%h w%0d want 0000bbaa@0020 w1", log_d[b], log_a[b], log_w[b]); else pass_n++;
        chk_n++; if (log_a[b+1] !== 16'h0022 || log_d[b+1] !== 32'h000000CC || log_w[b+1] !== BYTE)
            $display("FAIL tail_byte: got %h@%h w%0d want 000000cc@0022 w0", log_d[b+1], log_a[b+1], log_w[b+1]); else pass_n++;
        chk_n++; if (log_t[b+1] - log_t[b] !== 10) $display("FAIL tail_gap: got %0t want 10", log_t[b+1] - log_t[b]); else pass_n++;
        chk_n++; if ({done, error} !== 2'b10) $display("FAIL tail_flags: got %b want 10", {done, error}); else pass_n++;
    endtask

    task automatic test_misaligned;
        int b;
        b = wr_n;
        send_hdr(32'h0000_0102, 32'd4);
        chk_n++; if (done !== 1'b0) $display("FAIL mis_done_clr: got %b want 0", done); else pass_n++;
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        chk_n++; if (busy !== 1'b1) $display("FAIL mis_busy4: got %b want 1", busy); else pass_n++;
        send_byte(8'h00);
        @(negedge clk);
        chk_n++; if ({busy, done, error} !== 3'b001) $display("FAIL mis_flags: got %b want 001", {busy, done, error}); else pass_n++;
        chk_n++; if (wr_n - b !== 0) $display("FAIL mis_writes: got %0d want 0", wr_n - b); else pass_n++;
        send_hdr(32'h0000_0040, 32'd4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h04);
        repeat (2) @(negedge clk);
        chk_n++; if (wr_n - b !== 1 || log_a[b] !== 16'h0040 || log_d[b] !== 32'h04030201)
            $display("FAIL resync: got %0d writes %h@%h want 1 04030201@0040", wr_n - b, log_d[b], log_a[b]); else pass_n++;
        chk_n++; if ({done, error} !== 2'b10) $display("FAIL resync_flags: got %b want 10", {done, error}); else pass_n++;
    endtask

    task automatic test_bad_csum;
        int b;
        b = wr_n;
        send_hdr(32'h0000_0200, 32'd4);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        chk_n++; if (wr_n - b !== 1 || log_d[b] !== 32'hEFBEADDE || log_a[b] !== 16'h0200)
            $display("FAIL bad_cs_write: got %0d writes %h@%h want 1 efbeadde@0200", wr_n - b, log_d[b], log_a[b]); else pass_n++;
        chk_n++; if ({busy, done, error} !== 3'b001) $display("FAIL bad_cs_flags: got %b want 001", {busy, done, error}); else pass_n++;
    endtask

    task automatic test_reset_mid_frame;
        int b;
        b = wr_n;
        send_hdr(32'h0000_0300, 32'd8);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        rst_n = 1'b0;
        #1;
        chk_n++; if ({busy, done, error, mem_write_enable, rx_ready} !== 5'b00000)
            $display("FAIL mid_rst_out: got %b want 00000", {busy, done, error, mem_write_enable, rx_ready}); else pass_n++;
        chk_n++; if (mem_addr !== '0 || mem_width !== WORD) $display("FAIL mid_rst_port: got %h w%0d want 0000 w2", mem_addr, mem_width); else pass_n++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_n++; if (wr_n - b !== 1 || log_d[b] !== 32'h44332211 || log_a[b] !== 16'h0300)
            $display("FAIL mid_rst_writes: got %0d writes %h@%h want 1 44332211@0300", wr_n - b, log_d[b], log_a[b]); else pass_n++;
        send_hdr(32'h0000_0010, 32'd4);
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        chk_n++; if (wr_n - b !== 2 || log_d[b+1] !== 32'hFF005AA5 || log_a[b+1] !== 16'h0010)
            $display("FAIL post_rst_frame: got %0d writes %h@%h want 2 ff005aa5@0010", wr_n - b, log_d[b+1], log_a[b+1]); else pass_n++;
        chk_n++; if ({done, error} !== 2'b10) $display("FAIL post_rst_flags: got %b want 10", {done, error}); else pass_n++;
    endtask

    task automatic test_garbage_len0;
        int b;
        b = wr_n;
        jitter = 1'b1;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        @(negedge clk);
        chk_n++; if (busy !== 1'b0) $display("FAIL garbage_busy: got %b want 0", busy); else pass_n++;
        send_hdr(32'h0000_0080, 32'd0);
        chk_n++; if (done !== 1'b0) $display("FAIL len0_done_clr: got %b want 0", done); else pass_n++;
        send_byte(8'h00);
        jitter = 1'b0;
        repeat (2) @(negedge clk);
        chk_n++; if (wr_n - b !== 0) $display("FAIL len0_writes: got %0d want 0", wr_n - b); else pass_n++;
        chk_n++; if ({busy, done, error} !== 3'b010) $display("FAIL len0_flags: got %b want 010", {busy, done, error}); else pass_n++;
    endtask

    initial begin
        test_reset;
        test_word_frame;
        test_tail3;
        test_misaligned;
        test_bad_csum;
        test_reset_mid_frame;
        test_garbage_len0;
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1);
    end

endmodule
